uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL provide parameter PARITY_EN, default 0, meaning 1 = insert even-parity bit between data and stop, 0 = 8N1 frame.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge; one clock domain only.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port tx_start, input, 1, request to send tx_data; level sampled each cycle.
REQ-006 SHALL have port tx_data, input, 8, byte to transmit; sampled only on an accepted start.
REQ-007 SHALL have port SerialDataOut, output, 1, serial line, idle high, registered.
REQ-008 SHALL have port tx_busy, output, 1, high while a frame is in progress, registered.
REQ-009 SHALL have port tx_done, output, 1, single-cycle pulse marking frame completion, registered.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; state, baud counter (16 bit), bit index (3 bit), shift register (8 bit) all registered.
REQ-011 In IDLE, tx_start=1 at rising edge SHALL be accepted: latch tx_data, clear baud counter, go to START, SerialDataOut=0 and tx_busy=1 from that edge.
REQ-012 tx_start SHALL be ignored in every state other than IDLE, including the cycle tx_done is high; no queuing.
REQ-013 Baud counter SHALL count 0..CLKS_PER_BIT-1; each state holds its line value exactly CLKS_PER_BIT cycles, counter wraps to 0 on each bit boundary.
REQ-014 START -> DATA after CLKS_PER_BIT cycles; DATA SHALL drive bits LSB first, bit index 0..7, advancing once per bit period.
REQ-015 After bit 7: DATA -> PARITY if PARITY_EN=1, else DATA -> STOP.
REQ-016 PARITY SHALL drive XOR of the 8 latched bits (even parity) for one bit period, then -> STOP.
REQ-017 STOP SHALL drive 1 for one bit period, then -> IDLE; in that same edge tx_done=1 for exactly one cycle and tx_busy=0.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) from accepting edge to tx_done edge.
REQ-019 Changes on tx_data after acceptance SHALL NOT affect the frame in progress.
REQ-020 Back-to-back: tx_start held high continuously SHALL yield frames separated by exactly one idle-high cycle (the tx_done cycle).
REQ-021 Unreachable state encodings SHALL recover to IDLE next cycle with outputs at reset values.

Reset
REQ-022 reset=0 at rising edge SHALL force state IDLE, SerialDataOut=1, tx_busy=0, tx_done=0, counters and shift register 0, regardless of state.
REQ-023 Reset mid-frame SHALL abort the frame with no tx_done pulse; line high from the next edge.
REQ-024 tx_start SHALL be ignored in any cycle where reset=0.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-025 Send 0xA5, PARITY_EN=0 -> line samples per bit: 0,1,0,1,0,0,1,0,1,1; each held 4 cycles; tx_done at cycle 40 after accept.
REQ-026 Send 0x07, PARITY_EN=1 -> start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1; tx_done at cycle 44.
REQ-027 tx_start pulsed at cycles 8 and 39 of a frame, tx_data toggled mid-frame -> single frame of original byte, both pulses ignored.
REQ-028 tx_start held high, bytes 0x00 then 0xFF -> two frames, one high cycle between stop and next start, two tx_done pulses 41 cycles apart.
REQ-029 reset=0 asserted during DATA bit 3 -> next edge line=1, tx_busy=0, no tx_done; new start after release produces clean frame.
REQ-030 CLKS_PER_BIT=434 default, send 0x55 -> every bit width 434 cycles, total 4340 cycles, checked by bit-timing monitor.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// The serial line, busy flag and done pulse all come straight from flops.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       SerialDataOut,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                line_q, line_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                bit_end;
  logic [CNT_W-1:0]    cnt_next;

  // Bit boundary: the current line value has been held for a full bit period.
  assign bit_end  = (cnt_q == CNT_LAST);
  assign cnt_next = bit_end ? '0 : cnt_q + 16'd1;

  // Registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and next (registered) output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    line_d  = line_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        line_d = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d = START;
          shreg_d = tx_data;
          par_d   = ^tx_data;
          line_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          state_d = DATA;
          line_d  = shreg_q[0];
        end
      end

      DATA: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              line_d  = par_q;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
            line_d  = shreg_q[1];
          end
        end
      end

      PARITY: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          state_d = STOP;
          line_d  = 1'b1;
        end
      end

      STOP: begin
        cnt_d = cnt_next;
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          line_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      // Illegal encodings fall back to the reset picture.
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        shreg_d = '0;
        par_d   = 1'b0;
        line_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign SerialDataOut = line_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected line sequences, a monitor
// checks every bit period, the done edge and frame aborts on the selected instance.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CPB      = 4;
  localparam int unsigned CPB_LONG = 434;

  typedef struct {
    logic [10:0] bits;      // line values in transmit order, bit 0 first
    int          nbits;
    int          abort_at;  // cycle after accept where reset has taken effect, -1 none
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [7:0] data;
  logic [2:0] line, busy, done;

  int    sel;
  logic  line_m, busy_m, done_m;
  int    cpb_m;

  item_t sb_q[$];
  bit    mon_busy = 1'b0;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    dc[3]    = '{0, 0, 0};
  int    cyc_g    = 0;
  int    t_prev   = 0;
  int    t_last   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_np (
    .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(data),
    .SerialDataOut(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(data),
    .SerialDataOut(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx #(.CLKS_PER_BIT(CPB_LONG), .PARITY_EN(1'b0)) u_long (
    .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(data),
    .SerialDataOut(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  assign line_m = (sel == 0) ? line[0] : (sel == 1) ? line[1] : line[2];
  assign busy_m = (sel == 0) ? busy[0] : (sel == 1) ? busy[1] : busy[2];
  assign done_m = (sel == 0) ? done[0] : (sel == 1) ? done[1] : done[2];
  assign cpb_m  = (sel == 2) ? int'(CPB_LONG) : int'(CPB);

  // Done-pulse bookkeeping for all instances.
  always @(negedge clk) begin
    cyc_g <= cyc_g + 1;
    for (int i = 0; i < 3; i++)
      if (done[i]) dc[i] <= dc[i] + 1;
    if (done[0]) begin
      t_prev <= t_last;
      t_last <= cyc_g;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [10:0] bits, input int nbits, input int abort_at);
    item_t it;
    it.bits     = bits;
    it.nbits    = nbits;
    it.abort_at = abort_at;
    sb_q.push_back(it);
  endtask

  // One-cycle start pulse; returns on the first sample after the accepting edge.
  task automatic send(input int d, input logic [7:0] b);
    start[d] = 1'b1;
    data     = b;
    tick(1);
    start[d] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
      tick(1);
      n++;
    end
    check("drain within budget", int'(sb_q.size() == 0 && !mon_busy), 1);
  endtask

  // Checks one frame starting at the current sample (cycle 0 after accept).
  task automatic check_frame(input item_t it);
    int good;
    int k;
    mon_busy = 1'b1;
    for (int b = 0; b < it.nbits; b++) begin
      good = 0;
      for (int c = 0; c < cpb_m; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        k = b * cpb_m + c;
        if (k == it.abort_at) begin
          check("abort {line,busy,done}", int'({line_m, busy_m, done_m}), 4);
          mon_busy = 1'b0;
          return;
        end
        if (line_m == it.bits[b] && busy_m && !done_m) good++;
      end
      check($sformatf("dut%0d bit %0d hold", sel, b), good, cpb_m);
    end
    @(negedge clk);
    check($sformatf("dut%0d done edge {line,busy,done}", sel), int'({line_m, busy_m, done_m}), 5);
    mon_busy = 1'b0;
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (reset && busy_m && !line_m) begin
        check("frame start was expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          it = sb_q.pop_front();
          check_frame(it);
        end else begin
          for (int i = 0; i < 20000 && busy_m; i++) @(negedge clk);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    start = '0;
    data  = '0;
    sel   = 0;
    tick(3);
    for (int d = 0; d < 3; d++)
      check($sformatf("dut%0d reset {line,busy,done}", d), int'({line[d], busy[d], done[d]}), 4);
    reset = 1'b1;
    tick(2);

    // 0xA5, 8N1
    sel = 0;
    push(11'b011_0100_1010, 10, -1);
    send(0, 8'hA5);
    drain(100);
    tick(3);

    // 0x07 with even parity
    sel = 1;
    push(11'b110_0000_1110, 11, -1);
    send(1, 8'h07);
    drain(100);
    tick(3);

    // Starts mid-frame and in the last stop cycle are ignored; data changes ignored
    sel = 0;
    push(11'b010_1011_0100, 10, -1);
    send(0, 8'h5A);
    tick(8);
    start[0] = 1'b1;
    data     = 8'h3C;
    tick(1);
    start[0] = 1'b0;
    data     = 8'hFF;
    tick(30);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    drain(100);
    tick(5);
    check("done count after ignored starts", dc[0], 2);

    // Back-to-back with tx_start held: 0x00 then 0xFF
    push(11'b010_0000_0000, 10, -1);
    push(11'b011_1111_1110, 10, -1);
    start[0] = 1'b1;
    data     = 8'h00;
    tick(1);
    data     = 8'hFF;
    tick(41);
    start[0] = 1'b0;
    drain(150);
    tick(3);
    check("back-to-back done gap", t_last - t_prev, 41);
    check("done count after back-to-back", dc[0], 4);

    // Reset during data bit 3 aborts the frame; start ignored while in reset
    push(11'b011_1000_0110, 10, 19);
    send(0, 8'hC3);
    tick(18);
    reset = 1'b0;
    tick(1);
    start[0] = 1'b1;
    data     = 8'h11;
    tick(2);
    reset    = 1'b1;
    start[0] = 1'b0;
    tick(10);
    check("no done after abort", dc[0], 4);
    check("idle after abort {line,busy,done}", int'({line[0], busy[0], done[0]}), 4);
    drain(20);
    push(11'b011_0010_1100, 10, -1);
    send(0, 8'h96);
    drain(100);
    tick(3);
    check("done count after clean frame", dc[0], 5);

    // 0x55 at 434 clocks per bit
    sel = 2;
    push(11'b010_1010_1010, 10, -1);
    send(2, 8'h55);
    drain(5000);
    tick(3);
    check("parity dut done count", dc[1], 1);
    check("long dut done count", dc[2], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
